scc_channel_scheduler: RTL and testbench

- Time-slot sequencer for the SCC wave engine.
- Drives the 3-bit channel index that selects one of six channel registers, A..F, on the shared 6-way selector.
- Time-multiplexes one 12-bit frequency down-counter datapath and one 5-bit wave-address incrementer across all six channels.
- Emits the per-slot wave-table read address. Sits between the register file and the wave RAM / mixer.

---
 rtl/scc_pkg.sv | 13 +
 rtl/scc_channel_counter_step.sv | 31 +++
 rtl/scc_channel_scheduler.sv | 121 ++++++++++++
 tb/tb_scc_channel_scheduler.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scc_pkg.sv
// Shared constants for the SCC channel scheduler and its counter step.
package scc_pkg;
   localparam int SCC_CH_NUM          = 6;
   localparam int SCC_FREQ_BITS       = 12;
   localparam int SCC_ADDR_BITS       = 5;
   localparam int SCC_MIN_FREQ        = 9;
   localparam int SCC_SLOT_IDLE_FIRST = 6;
   localparam int SCC_SLOT_BITS       = 3;

   function automatic logic scc_slot_is_channel(input logic [SCC_SLOT_BITS-1:0] slot);
      return slot < SCC_SLOT_BITS'(SCC_SLOT_IDLE_FIRST);
   endfunction
endpackage

// File: rtl/scc_channel_counter_step.sv
// Shared frequency down-counter and wave-address incrementer for one channel visit.
module scc_channel_counter_step
   import scc_pkg::*;
#(
   parameter int FREQ_BITS = SCC_FREQ_BITS,
   parameter int ADDR_BITS = SCC_ADDR_BITS,
   parameter int MIN_FREQ  = SCC_MIN_FREQ
) (
   input  logic [FREQ_BITS-1:0] cnt,
   input  logic [ADDR_BITS-1:0] addr,
   input  logic [FREQ_BITS-1:0] freq,
   input  logic                 enable,
   output logic [FREQ_BITS-1:0] cnt_next,
   output logic [ADDR_BITS-1:0] addr_next
);

   // Frequencies below MIN_FREQ halt the channel without touching its phase.
   always_comb begin
      cnt_next  = cnt;
      addr_next = addr;
      if (enable && (freq >= FREQ_BITS'(MIN_FREQ))) begin
         if (cnt == '0) begin
            cnt_next  = freq;
            addr_next = addr + ADDR_BITS'(1);
         end else begin
            cnt_next  = cnt - FREQ_BITS'(1);
         end
      end
   end

endmodule

// File: rtl/scc_channel_scheduler.sv
// SCC 8-slot channel sequencer with one time-shared counter/address datapath.
// Optional: SCC_FREQ_WR_RESET_EN makes freq_wr[n] restart channel n's period.
module scc_channel_scheduler
   import scc_pkg::*;
#(
   parameter int CH_NUM    = SCC_CH_NUM,
   parameter int FREQ_BITS = SCC_FREQ_BITS,
   parameter int ADDR_BITS = SCC_ADDR_BITS,
   parameter int MIN_FREQ  = SCC_MIN_FREQ
) (
   input  logic                        clk,
   input  logic                        nreset,
   input  logic                        clk_en,
   input  logic [CH_NUM*FREQ_BITS-1:0] freq,
   input  logic [CH_NUM-1:0]           ch_enable,
   input  logic [CH_NUM-1:0]           freq_wr,
   output logic [2:0]                  active,
   output logic [ADDR_BITS-1:0]        wave_addr,
   output logic                        addr_valid,
   output logic                        slot_end
);

   logic [2:0]           slot_q, slot_d;
   logic [FREQ_BITS-1:0] cnt_q [CH_NUM];
   logic [FREQ_BITS-1:0] cnt_d [CH_NUM];
   logic [ADDR_BITS-1:0] addr_q [CH_NUM];
   logic [ADDR_BITS-1:0] addr_d [CH_NUM];
   logic [ADDR_BITS-1:0] wave_addr_q, wave_addr_d;
   logic                 addr_valid_q, addr_valid_d;
   logic                 slot_end_q, slot_end_d;

   logic                 slot_live, new_live, step_en;
   logic [2:0]           ch_idx, new_idx;
   logic [FREQ_BITS-1:0] step_cnt;
   logic [ADDR_BITS-1:0] step_addr;

   always_comb begin
      slot_live = slot_q < 3'(CH_NUM);
      ch_idx    = slot_live ? slot_q : 3'd0;
`ifdef SCC_FREQ_WR_RESET_EN
      step_en   = slot_live && ch_enable[ch_idx] && !freq_wr[ch_idx];
`else
      step_en   = slot_live && ch_enable[ch_idx];
`endif
   end

`ifndef SCC_FREQ_WR_RESET_EN
   logic unused_freq_wr;
   assign unused_freq_wr = ^freq_wr;
`endif

   scc_channel_counter_step #(
      .FREQ_BITS (FREQ_BITS),
      .ADDR_BITS (ADDR_BITS),
      .MIN_FREQ  (MIN_FREQ)
   ) u_step (
      .cnt       (cnt_q[ch_idx]),
      .addr      (addr_q[ch_idx]),
      .freq      (freq[ch_idx*FREQ_BITS +: FREQ_BITS]),
      .enable    (step_en),
      .cnt_next  (step_cnt),
      .addr_next (step_addr)
   );

   // Outputs look at the slot being entered, using its address after this edge's update.
   always_comb begin
      slot_d       = slot_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      wave_addr_d  = wave_addr_q;
      addr_valid_d = addr_valid_q;
      slot_end_d   = 1'b0;
      new_live     = 1'b0;
      new_idx      = 3'd0;
      if (clk_en) begin
         slot_d     = slot_q + 3'd1;
         slot_end_d = (slot_q == 3'd7);
         if (slot_live) begin
            cnt_d[ch_idx]  = step_cnt;
            addr_d[ch_idx] = step_addr;
         end
         new_live     = slot_d < 3'(CH_NUM);
         new_idx      = new_live ? slot_d : 3'd0;
         wave_addr_d  = new_live ? addr_d[new_idx] : '0;
         addr_valid_d = new_live && ch_enable[new_idx];
      end
`ifdef SCC_FREQ_WR_RESET_EN
      for (int n = 0; n < CH_NUM; n++) begin
         if (freq_wr[n]) cnt_d[n] = '0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         slot_q       <= 3'd0;
         wave_addr_q  <= '0;
         addr_valid_q <= 1'b0;
         slot_end_q   <= 1'b0;
         for (int n = 0; n < CH_NUM; n++) begin
            cnt_q[n]  <= '0;
            addr_q[n] <= '0;
         end
      end else begin
         slot_q       <= slot_d;
         wave_addr_q  <= wave_addr_d;
         addr_valid_q <= addr_valid_d;
         slot_end_q   <= slot_end_d;
         for (int n = 0; n < CH_NUM; n++) begin
            cnt_q[n]  <= cnt_d[n];
            addr_q[n] <= addr_d[n];
         end
      end
   end

   assign active     = slot_q;
   assign wave_addr  = wave_addr_q;
   assign addr_valid = addr_valid_q;
   assign slot_end   = slot_end_q;

endmodule

// File: tb/tb_scc_channel_scheduler.sv
// Scoreboard bench for scc_channel_scheduler; reference model follows the channel rules directly.
// Honours SCC_FREQ_WR_RESET_EN the same way the design build does.
module tb_scc_channel_scheduler;
   localparam int CH   = 6;
   localparam int FB   = 12;
   localparam int AB   = 5;
   localparam int MINF = 9;

   logic           clk = 1'b0;
   logic           nreset;
   logic           clk_en;
   logic [CH*FB-1:0] freq;
   logic [CH-1:0]  ch_enable;
   logic [CH-1:0]  freq_wr;
   logic [2:0]     active;
   logic [AB-1:0]  wave_addr;
   logic           addr_valid;
   logic           slot_end;

   typedef struct {
      int active;
      int wave;
      bit valid;
      bit send;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   // Reference model state: plain integers per channel plus the frame position.
   int m_cnt[CH];
   int m_addr[CH];
   int m_slot;
   int o_active, o_wave;
   bit o_valid, o_end;

   scc_channel_scheduler dut (
      .clk        (clk),
      .nreset     (nreset),
      .clk_en     (clk_en),
      .freq       (freq),
      .ch_enable  (ch_enable),
      .freq_wr    (freq_wr),
      .active     (active),
      .wave_addr  (wave_addr),
      .addr_valid (addr_valid),
      .slot_end   (slot_end)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Evaluates the rules for the coming clock edge, queues the expected outputs, then waits.
   task automatic applyStimulus();
      int   s, f;
      bit   clr[CH];
      exp_t e;
      if (!nreset) begin
         for (int n = 0; n < CH; n++) begin
            m_cnt[n]  = 0;
            m_addr[n] = 0;
         end
         m_slot = 0; o_active = 0; o_wave = 0; o_valid = 0; o_end = 0;
      end else begin
         for (int n = 0; n < CH; n++) clr[n] = 1'b0;
`ifdef SCC_FREQ_WR_RESET_EN
         for (int n = 0; n < CH; n++) clr[n] = freq_wr[n];
`endif
         if (clk_en) begin
            s = m_slot;
            if (s < CH && ch_enable[s] && !clr[s]) begin
               f = int'(freq[s*FB +: FB]);
               if (f >= MINF) begin
                  if (m_cnt[s] == 0) begin
                     m_cnt[s]  = f;
                     m_addr[s] = (m_addr[s] + 1) % 32;
                  end else begin
                     m_cnt[s] = m_cnt[s] - 1;
                  end
               end
            end
            o_end    = (s == 7);
            m_slot   = (s + 1) % 8;
            o_active = m_slot;
            o_valid  = (m_slot < CH) ? ch_enable[m_slot] : 1'b0;
            o_wave   = (m_slot < CH) ? m_addr[m_slot] : 0;
         end else begin
            o_end = 1'b0;
         end
         for (int n = 0; n < CH; n++) if (clr[n]) m_cnt[n] = 0;
      end
      e.active = o_active; e.wave = o_wave; e.valid = o_valid; e.send = o_end;
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic checkOutput(input exp_t e);
      checks++;
      if (int'(active) != e.active) begin
         errors++;
         $display("[TB] FAIL active: got %0d expected %0d at %0t", active, e.active, $time);
      end
      checks++;
      if (int'(wave_addr) != e.wave) begin
         errors++;
         $display("[TB] FAIL wave_addr: got %0d expected %0d (active %0d) at %0t", wave_addr, e.wave, e.active, $time);
      end
      checks++;
      if (addr_valid !== e.valid) begin
         errors++;
         $display("[TB] FAIL addr_valid: got %b expected %b (active %0d) at %0t", addr_valid, e.valid, e.active, $time);
      end
      checks++;
      if (slot_end !== e.send) begin
         errors++;
         $display("[TB] FAIL slot_end: got %b expected %b at %0t", slot_end, e.send, $time);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput(e);
         end
      end
   end

   task automatic run(input int n);
      for (int i = 0; i < n; i++) applyStimulus();
   endtask

   task automatic setFreq(input int ch, input int v);
      freq[ch*FB +: FB] = FB'(v);
   endtask

   task automatic doReset();
      nreset = 1'b0;
      run(1);
      nreset = 1'b1;
   endtask

   initial begin
      int ends, guard;
      nreset = 1'b0; clk_en = 1'b0; freq = '0; ch_enable = '0; freq_wr = '0;
      run(2);
      nreset = 1'b1;
      run(2);

      // Reset in the middle of a frame, then straight slot sequencing.
      for (int n = 0; n < CH; n++) setFreq(n, 9 + n);
      ch_enable = '1;
      clk_en = 1'b1;
      run(20);
      doReset();
      run(9);
      ends = 0;
      for (int i = 0; i < 64; i++) begin
         applyStimulus();
         if (slot_end) ends++;
      end
      checks++;
      if (ends != 8) begin
         errors++;
         $display("[TB] FAIL slot_end_count: got %0d expected 8", ends);
      end

      // Period: channel 0 at the minimum running frequency through a full wrap.
      freq = '0; setFreq(0, 9); ch_enable = 6'b000001;
      doReset();
      run(80 * 33);

      // Halt threshold, then release.
      freq = '0; setFreq(2, 8); ch_enable = 6'b000100;
      doReset();
      run(800);
      setFreq(2, 9);
      run(240);

      // Key-off hold on channel 3.
      freq = '0; setFreq(3, 9); ch_enable = 6'b001000;
      doReset();
      guard = 0;
      while (m_addr[3] != 7 && guard < 2000) begin
         applyStimulus();
         guard++;
      end
      checks++;
      if (m_addr[3] != 7) begin
         errors++;
         $display("[TB] FAIL keyoff_reach: got addr %0d expected 7 within 2000 cycles", m_addr[3]);
      end
      ch_enable = '0;
      run(400);
      ch_enable = 6'b001000;
      run(160);

      // Frequency write while channel 1 is mid-count on a long period.
      freq = '0; setFreq(1, 4095); ch_enable = 6'b000010;
      doReset();
      run(160);
      setFreq(1, 9);
      freq_wr = 6'b000010;
      run(1);
      freq_wr = '0;
      run(120);

      // Randomised traffic including stalls, halts, writes and occasional resets.
      for (int i = 0; i < 3000; i++) begin
         clk_en  = ($urandom_range(0, 3) != 0);
         freq_wr = '0;
         for (int n = 0; n < CH; n++) begin
            if ($urandom_range(0, 15) == 0) freq_wr[n] = 1'b1;
            if ($urandom_range(0, 63) == 0) setFreq(n, int'($urandom_range(0, 20)));
         end
         if ($urandom_range(0, 31) == 0) ch_enable = CH'($urandom);
         nreset = ($urandom_range(0, 499) != 0);
         applyStimulus();
      end
      nreset = 1'b1; freq_wr = '0; clk_en = 1'b0;
      run(2);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
